// File: rtl/ifetch_cache.sv
// ifetch_cache: registered instruction-fetch unit with a direct-mapped instruction cache.
//   The cache holds 2**INDEX_BITS lines of one instruction each and compares the full tag.
//   Misses are sent to the memory controller through if_addr/if_request/if_inst_i/if_enable.
//   A jump aborts the current fetch, and icache_flush (fence.i) invalidates every line.
// Optional feature: define IFETCH_STATS_EN to add the saturating hit_cnt/miss_cnt counters.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   rdy                      global ready; low freezes all state and outputs
//   pc_reg_rdy, if_pc_i      fetch request and fetch PC
//   jump_or_not              redirect; aborts the fetch in flight
//   icache_flush             invalidates every line
//   if_pc_o, if_inst_o       delivered PC and instruction
//   if_valid_o               one-cycle pulse that marks a delivered instruction
//   if_stall                 high while a miss is outstanding
//   if_addr, if_request      miss request to the memory controller
//   if_inst_i, if_enable     instruction returned by the memory controller
//   hit_cnt, miss_cnt        lookup statistics (IFETCH_STATS_EN only)
module ifetch_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  pc_reg_rdy,
  input  logic [ADDR_WIDTH-1:0] if_pc_i,
  input  logic                  jump_or_not,
  input  logic                  icache_flush,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic                  if_valid_o,
  output logic                  if_stall,
  output logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_request,
  input  logic [INST_WIDTH-1:0] if_inst_i,
`ifdef IFETCH_STATS_EN
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
`endif
  input  logic                  if_enable
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_next;

  logic [LINES-1:0]      line_vld;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [INST_WIDTH-1:0] data_mem [LINES];

  // Lookup stage: index/tag of the requested PC and of the outstanding miss
  logic [INDEX_BITS-1:0] idx_p0, fill_idx_p0;
  logic [TAG_W-1:0]      tag_p0, fill_tag_p0;
  logic                  hit_p0;
  logic                  lookup_hit, lookup_miss, fill_done;

  assign idx_p0      = if_pc_i[INDEX_BITS+1:2];
  assign tag_p0      = if_pc_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_idx_p0 = if_addr[INDEX_BITS+1:2];
  assign fill_tag_p0 = if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  // A lookup that coincides with a flush must not use lines that are about to be invalidated.
  assign hit_p0      = line_vld[idx_p0] && (tag_mem[idx_p0] == tag_p0) && !icache_flush;

  // Byte-offset bits are never used because fetch addresses are word aligned.
  logic unused_ok;
  assign unused_ok = &{1'b0, if_pc_i[1:0], if_addr[1:0]};

  always_comb begin
    state_next  = state;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    fill_done   = 1'b0;
    case (state)
      IDLE: begin
        // A jump overrides a simultaneous lookup, whether it hits or misses.
        if (pc_reg_rdy && !jump_or_not) begin
          if (hit_p0) begin
            lookup_hit = 1'b1;
          end else begin
            lookup_miss = 1'b1;
            state_next  = MISS;
          end
        end
      end
      MISS: begin
        if (jump_or_not) begin
          state_next = IDLE;
        end else if (if_enable) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Output stage: registered fetch results and the memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_o    <= '0;
      if_inst_o  <= '0;
      if_valid_o <= 1'b0;
      if_stall   <= 1'b0;
      if_addr    <= '0;
      if_request <= 1'b0;
      line_vld   <= '0;
    end else if (rdy) begin
      if_valid_o <= 1'b0;
      if (lookup_hit) begin
        if_pc_o    <= if_pc_i;
        if_inst_o  <= data_mem[idx_p0];
        if_valid_o <= 1'b1;
        if_stall   <= 1'b0;
      end
      if (lookup_miss) begin
        if_addr    <= if_pc_i;
        if_request <= 1'b1;
        if_stall   <= 1'b1;
      end
      if (fill_done) begin
        if_pc_o    <= if_addr;
        if_inst_o  <= if_inst_i;
        if_valid_o <= 1'b1;
        if_request <= 1'b0;
        if_stall   <= 1'b0;
      end
      // Dropping the request is what tells the memory controller to cancel.
      if (state == MISS && jump_or_not) begin
        if_request <= 1'b0;
        if_stall   <= 1'b0;
      end
      // A flush wins over a simultaneous fill: the instruction is delivered but not cached.
      if (icache_flush) begin
        line_vld <= '0;
      end else if (fill_done) begin
        line_vld[fill_idx_p0] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill_done && !icache_flush) begin
      tag_mem[fill_idx_p0]  <= fill_tag_p0;
      data_mem[fill_idx_p0] <= if_inst_i;
    end
  end

`ifdef IFETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (lookup_hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end
      if (lookup_miss) begin
        miss_cnt <= sat_inc(miss_cnt);
      end
    end
  end
`endif

endmodule
